// File: rtl/c1_bus_responder.sv
// Cache-side responder for the C1/D1/A1 CPU bus: decodes a two-cycle command,
// services it against a byte-addressed store and answers after a fixed latency.
module c1_bus_responder #(
  parameter int ADDR1_BITS  = 15,
  parameter int OFFSET_BITS = 4,
  parameter int MEM_BYTES   = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR1_BITS-1:0] A1,
  inout  wire  [2:0]            C1,
  inout  wire  [15:0]           D1,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int FW = ADDR1_BITS + OFFSET_BITS;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_READ8    = 3'd1;
  localparam logic [2:0] CMD_READ16   = 3'd2;
  localparam logic [2:0] CMD_READ32   = 3'd3;
  localparam logic [2:0] CMD_WRITE8   = 3'd5;
  localparam logic [2:0] CMD_WRITE16  = 3'd6;
  localparam logic [2:0] CMD_WRITE32  = 3'd7;
  localparam logic [2:0] CMD_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD2  = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP1 = 3'd3,
    S_RESP2 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            cmd_q;
  logic [ADDR1_BITS-1:0] line_q;
  logic [15:0]           d_lo_q;
  logic [31:0]           rdata_q;
  logic [CW-1:0]         cnt_q;

  logic [7:0]            mem [MEM_BYTES];

  logic [FW-1:0]         full_addr;
  logic [AW-1:0]         a0, a1, a2, a3;
  logic                  unused_addr;
  logic                  cmd_is_read;

  logic                  c1_oe;
  logic [2:0]            c1_val;
  logic                  d1_oe;
  logic [15:0]           d1_val;

  // The offset is only valid on A1 during the second command cycle, so the
  // byte address is formed from the latched line and the live A1 low bits.
  assign full_addr   = {line_q, A1[OFFSET_BITS-1:0]};
  assign a0          = full_addr[AW-1:0];
  assign a1          = a0 + AW'(1);
  assign a2          = a0 + AW'(2);
  assign a3          = a0 + AW'(3);
  assign unused_addr = ^full_addr[FW-1:AW];

  assign cmd_is_read = (cmd_q == CMD_READ8) || (cmd_q == CMD_READ16) ||
                       (cmd_q == CMD_READ32);

  always_comb begin
    state_d = state_q;
    c1_oe   = 1'b0;
    c1_val  = CMD_NOP;
    d1_oe   = 1'b0;
    d1_val  = 16'h0000;
    case (state_q)
      S_IDLE: begin
        if (C1 != CMD_NOP) state_d = S_CMD2;
      end
      S_CMD2: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        c1_oe  = 1'b1;
        c1_val = CMD_NOP;
        if (cnt_q == CW'(1)) state_d = S_RESP1;
      end
      S_RESP1: begin
        c1_oe  = 1'b1;
        c1_val = CMD_RESPONSE;
        d1_oe  = cmd_is_read;
        d1_val = (cmd_q == CMD_READ8) ? {8'h00, rdata_q[7:0]} : rdata_q[15:0];
        state_d = (cmd_q == CMD_READ32) ? S_RESP2 : S_IDLE;
      end
      S_RESP2: begin
        c1_oe   = 1'b1;
        c1_val  = CMD_RESPONSE;
        d1_oe   = 1'b1;
        d1_val  = rdata_q[31:16];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 3'd0;
      line_q  <= '0;
      d_lo_q  <= 16'h0000;
      rdata_q <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_CMD2) begin
            cmd_q  <= C1;
            line_q <= A1;
            d_lo_q <= D1;
          end
        end
        S_CMD2: begin
          cnt_q <= CW'(LATENCY);
          if (cmd_is_read) rdata_q <= {mem[a3], mem[a2], mem[a1], mem[a0]};
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // The store is deliberately left without reset; a reset that lands before
  // the CMD2 edge returns the FSM to IDLE, so the pending write never commits.
  always_ff @(posedge clk) begin
    if (state_q == S_CMD2) begin
      case (cmd_q)
        CMD_WRITE8: begin
          mem[a0] <= d_lo_q[7:0];
        end
        CMD_WRITE16: begin
          mem[a0] <= d_lo_q[7:0];
          mem[a1] <= d_lo_q[15:8];
        end
        CMD_WRITE32: begin
          mem[a0] <= d_lo_q[7:0];
          mem[a1] <= d_lo_q[15:8];
          mem[a2] <= D1[7:0];
          mem[a3] <= D1[15:8];
        end
        default: ;
      endcase
    end
  end

  assign C1        = c1_oe ? c1_val : 3'bzzz;
  assign D1        = d1_oe ? d1_val : 16'hzzzz;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/c1_bus_responder.md
# c1_bus_responder

Cache-side responder for the CPU-to-cache C1/D1/A1 bus. Decodes commands issued by the CPU initiator, captures the two-cycle address/data phase, and services reads and writes against an internal byte-addressed store. After a fixed latency it returns `C1_RESPONSE`, plus read data for reads, then hands the bus back. It stands in for the cache so the CPU side can be exercised in isolation, and is the bus front end the real cache will reuse.

## Interface
- `ADDR1_BITS`, 15: width of A1; first-cycle A1 carries the line address (tag+set).
- `OFFSET_BITS`, 4: low A1 bits used as byte offset in the second cycle.
- `MEM_BYTES`, 1024: store size, power of two; byte address = {line, offset} mod `MEM_BYTES`.
- `LATENCY`, 4: NOP cycles before the response; must be ≥1.
- `clk` in 1: single clock; all sampling on posedge.
- `reset` in 1: asynchronous, active-high.
- `A1` in `ADDR1_BITS`: address from CPU.
- `C1` inout 3: command/response.
  - Codes: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7, RESPONSE=7.
- `D1` inout 16: data, little-endian; D1[7:0] is the lowest byte address.
- `busy` out 1: transaction in progress.

## Operation
- States: IDLE → CMD2 → WAIT → RESP1 → (RESP2 for READ32 only) → IDLE.
- IDLE:
  - C1/D1 high-Z.
  - At posedge with C1≠NOP: latch cmd, line=A1, d_lo=D1; go to CMD2.
- CMD2:
  - At the next posedge: latch offset=A1[OFFSET_BITS-1:0] and d_hi=D1.
  - Commit writes at this edge:
    - WRITE8 stores d_lo[7:0].
    - WRITE16 stores d_lo at addr and addr+1.
    - WRITE32 stores {d_hi,d_lo} at addr..addr+3.
  - Multi-byte addresses wrap mod `MEM_BYTES`; no alignment check.
  - Reads snapshot their data at this edge.
  - Go to WAIT with count=`LATENCY`.
- WAIT:
  - Drive C1=NOP; D1 high-Z.
  - Decrement each posedge; at count 1 go to RESP1.
- RESP1:
  - Drive C1=RESPONSE.
  - READ8: D1={8'h00, byte}. READ16: D1=halfword. READ32: D1=low half.
  - Writes/INVALIDATE: D1 high-Z.
  - Next: RESP2 if READ32, else IDLE.
- RESP2: drive C1=RESPONSE, D1=high half of READ32 data; then IDLE.
- INVALIDATE_LINE: no store change; response only.
- The store is not reset; contents are undefined until written.
- The command arriving in IDLE is decoded unconditionally. Commands appearing while not in IDLE are ignored. C1 is sampled only in IDLE.

## Timing
- Command seen at posedge k: CMD2 during [k,k+1).
- C1 drive begins after posedge k+1, giving one-cycle turnaround at the k+1 edge. NOP is driven for cycles k+1..k+LATENCY.
- RESPONSE is valid in the cycle after posedge k+LATENCY+1; READ32 high half follows one cycle later.
- C1/D1 are released after posedge k+LATENCY+2 (k+LATENCY+3 for READ32). The next command is accepted at the following posedge.
- Write-to-read ordering: a read issued after a write's response returns the written data.
- `busy`: 1 from posedge k until the release edge; 0 in IDLE.
- Reset:
  - Effective immediately regardless of clock.
  - `busy`=0; C1/D1 high-Z; state=IDLE; latched fields cleared.
  - Reset during CMD2 discards the write. Reset after the CMD2 edge keeps the committed write.
- D1 and C1 output enables always switch together with state, never combinationally from inputs.

## Test plan
- WRITE32 line=0x0010, off=0x4, D1 0xBEEF then 0xDEAD → RESPONSE after 4 NOP cycles. Then READ32 same address → RESPONSE D1=0xBEEF, next cycle 0xDEAD, then release.
- Read sizes and endianness:
  - WRITE16 0xA55A at off=0x2 → READ8 off=0x2 returns 0x005A.
  - READ8 off=0x3 returns 0x00A5.
  - READ16 off=0x2 returns 0xA55A.
- INVALIDATE_LINE line=0x0010 → single RESPONSE cycle, D1 high-Z; subsequent READ32 still returns 0xDEADBEEF.
- Latency sweep with `LATENCY`=1 and 7:
  - NOP cycle count equals `LATENCY`.
  - `busy` high exactly from the command edge to the release edge.
  - Back-to-back command accepted on the first idle edge.
- Wrap with `MEM_BYTES`=1024: WRITE32 0x11223344 at byte addr 1022 → bytes 1022,1023,0,1 = 44,33,22,11; READ16 at 0 returns 0x1122.
- Reset mid-operation:
  - Assert `reset` during WAIT of a READ32 → C1/D1 high-Z and `busy`=0 in the same cycle; next command is serviced normally.
  - Reset during CMD2 of WRITE8 leaves the target byte unchanged.
